// File: rtl/deal_scheduler.sv
// rtl/deal_scheduler.sv - blackjack round sequencer: card handshake, turn control, scoring, BCD win counters
module deal_scheduler #(
  parameter int DEALER_STAND = 17,
  parameter int BUST_LIMIT   = 21,
  parameter int MAX_CARDS    = 5
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        new_Game,
  input  logic        slave_hit,
  input  logic        slave_stand,
  input  logic        card_valid,
  input  logic [3:0]  cardValue4,
  output logic        card_req,
  output logic        cardReadySlave,
  output logic        cardReadyMaster,
  output logic [4:0]  totalValueSlave5,
  output logic [4:0]  totalValueMaster5,
  output logic        finishSlave,
  output logic        finishMaster,
  output logic [1:0]  result2,
  output logic [15:0] bcdResults16
);

  typedef enum logic [3:0] {
    IDLE, DEAL_S1, DEAL_M1, DEAL_S2, DEAL_M2, SLAVE_TURN, SLAVE_DRAW,
    MASTER_TURN, MASTER_DRAW, SCORE, DONE
  } state_t;

  localparam logic [4:0] STAND_LIM = 5'(DEALER_STAND);
  localparam logic [4:0] BUST_LIM  = 5'(BUST_LIMIT);
  localparam logic [2:0] MAX_CNT   = 3'(MAX_CARDS);

  state_t      state_q, state_d;
  logic        card_req_q, card_req_d;
  logic        rdy_s_q, rdy_s_d, rdy_m_q, rdy_m_d;
  logic [4:0]  tot_s_q, tot_s_d, tot_m_q, tot_m_d;
  logic [2:0]  cnt_s_q, cnt_s_d;
  logic        fin_s_q, fin_s_d, fin_m_q, fin_m_d;
  logic [1:0]  res_q, res_d;
  logic [15:0] bcd_q, bcd_d;

  logic       accept, to_slave, to_master, slave_bust;
  logic [4:0] card_pts;

  function automatic logic [4:0] sat_add(input logic [4:0] a, input logic [4:0] b);
    logic [5:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[5] ? 5'd31 : s[4:0];
  endfunction

  // Two-digit BCD increment that wraps 99 -> 00
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    logic [7:0] r;
    r = v;
    if (v[3:0] == 4'd9) begin
      r[3:0] = 4'd0;
      r[7:4] = (v[7:4] == 4'd9) ? 4'd0 : v[7:4] + 4'd1;
    end else begin
      r[3:0] = v[3:0] + 4'd1;
    end
    return r;
  endfunction

  function automatic logic is_card_state(input state_t s);
    return (s == DEAL_S1) || (s == DEAL_M1) || (s == DEAL_S2) || (s == DEAL_M2) ||
           (s == SLAVE_DRAW) || (s == MASTER_DRAW);
  endfunction

  assign accept     = card_req_q & card_valid;
  assign to_slave   = (state_q == DEAL_S1) || (state_q == DEAL_S2) || (state_q == SLAVE_DRAW);
  assign to_master  = (state_q == DEAL_M1) || (state_q == DEAL_M2) || (state_q == MASTER_DRAW);
  assign slave_bust = tot_s_q > BUST_LIM;

  always_comb begin
    card_pts = 5'd10;
    if (cardValue4 != 4'd0 && cardValue4 <= 4'd10) card_pts = {1'b0, cardValue4};
  end

  always_comb begin
    state_d = state_q;
    rdy_s_d = 1'b0;
    rdy_m_d = 1'b0;
    tot_s_d = tot_s_q;
    tot_m_d = tot_m_q;
    cnt_s_d = cnt_s_q;
    fin_s_d = fin_s_q;
    fin_m_d = fin_m_q;
    res_d   = res_q;
    bcd_d   = bcd_q;

    if (accept && to_slave) begin
      tot_s_d = sat_add(tot_s_q, card_pts);
      cnt_s_d = (cnt_s_q == 3'd7) ? 3'd7 : cnt_s_q + 3'd1;
      rdy_s_d = 1'b1;
    end
    if (accept && to_master) begin
      tot_m_d = sat_add(tot_m_q, card_pts);
      rdy_m_d = 1'b1;
    end

    case (state_q)
      IDLE:        state_d = IDLE;
      DEAL_S1:     if (accept) state_d = DEAL_M1;
      DEAL_M1:     if (accept) state_d = DEAL_S2;
      DEAL_S2:     if (accept) state_d = DEAL_M2;
      DEAL_M2:     if (accept) state_d = SLAVE_TURN;
      SLAVE_TURN: begin
        if (slave_bust || cnt_s_q == MAX_CNT || slave_stand) begin
          fin_s_d = 1'b1;
          state_d = MASTER_TURN;
        end else if (slave_hit) begin
          state_d = SLAVE_DRAW;
        end
      end
      SLAVE_DRAW:  if (accept) state_d = SLAVE_TURN;
      MASTER_TURN: begin
        if (!slave_bust && tot_m_q < STAND_LIM) begin
          state_d = MASTER_DRAW;
        end else begin
          fin_m_d = 1'b1;
          state_d = SCORE;
        end
      end
      MASTER_DRAW: if (accept) state_d = MASTER_TURN;
      SCORE: begin
        if (slave_bust)             res_d = 2'b10;
        else if (tot_m_q > BUST_LIM) res_d = 2'b01;
        else if (tot_s_q > tot_m_q) res_d = 2'b01;
        else if (tot_m_q > tot_s_q) res_d = 2'b10;
        else                        res_d = 2'b11;
        if (res_d == 2'b01) bcd_d[7:0]  = bcd_inc(bcd_q[7:0]);
        if (res_d == 2'b10) bcd_d[15:8] = bcd_inc(bcd_q[15:8]);
        state_d = DONE;
      end
      DONE:        state_d = DONE;
      default:     state_d = IDLE;
    endcase

    // A new round overrides everything, including a card accepted this cycle
    if (new_Game) begin
      state_d = DEAL_S1;
      rdy_s_d = 1'b0;
      rdy_m_d = 1'b0;
      tot_s_d = 5'd0;
      tot_m_d = 5'd0;
      cnt_s_d = 3'd0;
      fin_s_d = 1'b0;
      fin_m_d = 1'b0;
      res_d   = 2'b00;
    end

    card_req_d = is_card_state(state_d) && !accept && !new_Game;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      card_req_q <= 1'b0;
      rdy_s_q    <= 1'b0;
      rdy_m_q    <= 1'b0;
      tot_s_q    <= 5'd0;
      tot_m_q    <= 5'd0;
      cnt_s_q    <= 3'd0;
      fin_s_q    <= 1'b0;
      fin_m_q    <= 1'b0;
      res_q      <= 2'b00;
      bcd_q      <= 16'h0000;
    end else begin
      state_q    <= state_d;
      card_req_q <= card_req_d;
      rdy_s_q    <= rdy_s_d;
      rdy_m_q    <= rdy_m_d;
      tot_s_q    <= tot_s_d;
      tot_m_q    <= tot_m_d;
      cnt_s_q    <= cnt_s_d;
      fin_s_q    <= fin_s_d;
      fin_m_q    <= fin_m_d;
      res_q      <= res_d;
      bcd_q      <= bcd_d;
    end
  end

  assign card_req          = card_req_q;
  assign cardReadySlave    = rdy_s_q;
  assign cardReadyMaster   = rdy_m_q;
  assign totalValueSlave5  = tot_s_q;
  assign totalValueMaster5 = tot_m_q;
  assign finishSlave       = fin_s_q;
  assign finishMaster      = fin_m_q;
  assign result2           = res_q;
  assign bcdResults16      = bcd_q;

endmodule

// File: tb/tb_deal_scheduler.sv
// tb/tb_deal_scheduler.sv - directed self-checking bench for deal_scheduler
module tb_deal_scheduler;

  logic        clock = 1'b0;
  logic        reset, new_Game, slave_hit, slave_stand, card_valid;
  logic [3:0]  cardValue4;
  logic        card_req, cardReadySlave, cardReadyMaster;
  logic [4:0]  totalValueSlave5, totalValueMaster5;
  logic        finishSlave, finishMaster;
  logic [1:0]  result2;
  logic [15:0] bcdResults16;

  int errors = 0;
  int checks = 0;

  deal_scheduler dut (
    .clock(clock), .reset(reset), .new_Game(new_Game), .slave_hit(slave_hit),
    .slave_stand(slave_stand), .card_valid(card_valid), .cardValue4(cardValue4),
    .card_req(card_req), .cardReadySlave(cardReadySlave), .cardReadyMaster(cardReadyMaster),
    .totalValueSlave5(totalValueSlave5), .totalValueMaster5(totalValueMaster5),
    .finishSlave(finishSlave), .finishMaster(finishMaster), .result2(result2),
    .bcdResults16(bcdResults16)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic start_game();
    new_Game = 1'b1;
    tick();
    new_Game = 1'b0;
  endtask

  task automatic give_card(input logic [3:0] v);
    int n;
    n = 0;
    while (card_req !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (card_req !== 1'b1) begin
      errors++;
      $display("FAIL card_req_wait actual=%b required=1", card_req);
    end
    card_valid = 1'b1;
    cardValue4 = v;
    tick();
    card_valid = 1'b0;
  endtask

  task automatic deal4(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                       input logic [3:0] d);
    start_game();
    give_card(a);
    give_card(b);
    give_card(c);
    give_card(d);
  endtask

  task automatic pulse_hit();
    slave_hit = 1'b1;
    tick();
    slave_hit = 1'b0;
  endtask

  task automatic pulse_stand();
    slave_stand = 1'b1;
    tick();
    slave_stand = 1'b0;
  endtask

  task automatic wait_result(output int reqs);
    int n;
    n = 0;
    reqs = 0;
    while (result2 === 2'b00 && n < 50) begin
      if (card_req === 1'b1) reqs++;
      tick();
      n++;
    end
    checks++;
    if (result2 === 2'b00) begin
      errors++;
      $display("FAIL result_wait actual=%b required=nonzero", result2);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({card_req, cardReadySlave, cardReadyMaster, totalValueSlave5, totalValueMaster5,
         finishSlave, finishMaster, result2, bcdResults16} !== '0) begin
      errors++;
      $display("FAIL reset_outputs actual=%b required=0", {card_req, totalValueSlave5,
               totalValueMaster5, finishSlave, finishMaster, result2, bcdResults16});
    end
    start_game();
    give_card(4'd5);
    tick();
    checks++;
    if (card_req !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_req actual=%b required=1", card_req);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({card_req, cardReadySlave, cardReadyMaster, totalValueSlave5, totalValueMaster5,
         finishSlave, finishMaster, result2, bcdResults16} !== '0) begin
      errors++;
      $display("FAIL async_reset actual=%b required=0", {card_req, totalValueSlave5,
               totalValueMaster5, finishSlave, finishMaster, result2, bcdResults16});
    end
    tick();
    reset = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if (card_req !== 1'b0 || totalValueSlave5 !== 5'd0) begin
      errors++;
      $display("FAIL reset_idle actual=%b/%0d required=0/0", card_req, totalValueSlave5);
    end
  endtask

  task automatic test_basic_round();
    int reqs;
    deal4(4'd10, 4'd7, 4'd5, 4'd9);
    checks++;
    if (totalValueSlave5 !== 5'd15 || totalValueMaster5 !== 5'd16 || cardReadyMaster !== 1'b1) begin
      errors++;
      $display("FAIL basic_deal actual=%0d/%0d/%b required=15/16/1",
               totalValueSlave5, totalValueMaster5, cardReadyMaster);
    end
    pulse_stand();
    checks++;
    if (finishSlave !== 1'b1) begin
      errors++;
      $display("FAIL basic_finish_slave actual=%b required=1", finishSlave);
    end
    give_card(4'd3);
    checks++;
    if (totalValueMaster5 !== 5'd19 || cardReadyMaster !== 1'b1) begin
      errors++;
      $display("FAIL basic_master_draw actual=%0d/%b required=19/1", totalValueMaster5, cardReadyMaster);
    end
    wait_result(reqs);
    checks++;
    if (result2 !== 2'b10 || bcdResults16 !== 16'h0100 || finishMaster !== 1'b1) begin
      errors++;
      $display("FAIL basic_score actual=%b/%h/%b required=10/0100/1", result2, bcdResults16, finishMaster);
    end
  endtask

  task automatic test_slave_bust();
    int reqs;
    deal4(4'd10, 4'd2, 4'd6, 4'd3);
    pulse_hit();
    give_card(4'd12);
    checks++;
    if (totalValueSlave5 !== 5'd26 || cardReadySlave !== 1'b1) begin
      errors++;
      $display("FAIL bust_total actual=%0d/%b required=26/1", totalValueSlave5, cardReadySlave);
    end
    wait_result(reqs);
    checks++;
    if (reqs != 0 || finishSlave !== 1'b1 || finishMaster !== 1'b1) begin
      errors++;
      $display("FAIL bust_no_master_draw actual=%0d/%b/%b required=0/1/1", reqs, finishSlave, finishMaster);
    end
    checks++;
    if (result2 !== 2'b10 || bcdResults16 !== 16'h0200 || totalValueMaster5 !== 5'd5) begin
      errors++;
      $display("FAIL bust_score actual=%b/%h/%0d required=10/0200/5", result2, bcdResults16, totalValueMaster5);
    end
  endtask

  task automatic test_max_cards();
    int reqs;
    deal4(4'd2, 4'd10, 4'd3, 4'd10);
    pulse_hit();
    give_card(4'd2);
    tick();
    checks++;
    if (finishSlave !== 1'b0 || totalValueSlave5 !== 5'd7) begin
      errors++;
      $display("FAIL max_early_finish actual=%b/%0d required=0/7", finishSlave, totalValueSlave5);
    end
    pulse_hit();
    give_card(4'd4);
    pulse_hit();
    give_card(4'd5);
    wait_result(reqs);
    checks++;
    if (finishSlave !== 1'b1 || totalValueSlave5 !== 5'd16 || result2 !== 2'b10 ||
        bcdResults16 !== 16'h0300) begin
      errors++;
      $display("FAIL max_cards actual=%b/%0d/%b/%h required=1/16/10/0300",
               finishSlave, totalValueSlave5, result2, bcdResults16);
    end
  endtask

  task automatic test_hit_stand_and_stray();
    int reqs;
    deal4(4'd10, 4'd10, 4'd9, 4'd8);
    card_valid = 1'b1;
    cardValue4 = 4'd5;
    tick();
    tick();
    card_valid = 1'b0;
    checks++;
    if (totalValueSlave5 !== 5'd19 || totalValueMaster5 !== 5'd18 || cardReadySlave !== 1'b0) begin
      errors++;
      $display("FAIL stray_card actual=%0d/%0d/%b required=19/18/0",
               totalValueSlave5, totalValueMaster5, cardReadySlave);
    end
    slave_hit = 1'b1;
    slave_stand = 1'b1;
    tick();
    slave_hit = 1'b0;
    slave_stand = 1'b0;
    checks++;
    if (finishSlave !== 1'b1 || card_req !== 1'b0) begin
      errors++;
      $display("FAIL hit_stand actual=%b/%b required=1/0", finishSlave, card_req);
    end
    wait_result(reqs);
    checks++;
    if (reqs != 0 || result2 !== 2'b01 || bcdResults16 !== 16'h0301) begin
      errors++;
      $display("FAIL hit_stand_score actual=%0d/%b/%h required=0/01/0301", reqs, result2, bcdResults16);
    end
  endtask

  task automatic test_tie_and_master_bust();
    int reqs;
    deal4(4'd10, 4'd10, 4'd8, 4'd8);
    pulse_stand();
    wait_result(reqs);
    checks++;
    if (result2 !== 2'b11 || bcdResults16 !== 16'h0301) begin
      errors++;
      $display("FAIL tie actual=%b/%h required=11/0301", result2, bcdResults16);
    end
    deal4(4'd10, 4'd10, 4'd6, 4'd6);
    pulse_stand();
    give_card(4'd0);
    wait_result(reqs);
    checks++;
    if (totalValueMaster5 !== 5'd26 || result2 !== 2'b01 || bcdResults16 !== 16'h0302) begin
      errors++;
      $display("FAIL master_bust actual=%0d/%b/%h required=26/01/0302",
               totalValueMaster5, result2, bcdResults16);
    end
  endtask

  task automatic test_bcd_wrap();
    int reqs;
    for (int i = 0; i < 97; i++) begin
      deal4(4'd10, 4'd10, 4'd10, 4'd7);
      pulse_stand();
      wait_result(reqs);
      if (i == 7) begin
        checks++;
        if (bcdResults16 !== 16'h0310) begin
          errors++;
          $display("FAIL bcd_carry actual=%h required=0310", bcdResults16);
        end
      end
    end
    checks++;
    if (bcdResults16 !== 16'h0399 || result2 !== 2'b01) begin
      errors++;
      $display("FAIL bcd_99 actual=%h/%b required=0399/01", bcdResults16, result2);
    end
    deal4(4'd10, 4'd10, 4'd10, 4'd7);
    pulse_stand();
    wait_result(reqs);
    checks++;
    if (bcdResults16 !== 16'h0300 || result2 !== 2'b01) begin
      errors++;
      $display("FAIL bcd_wrap actual=%h/%b required=0300/01", bcdResults16, result2);
    end
  endtask

  task automatic test_restart_mid_deal();
    start_game();
    give_card(4'd4);
    give_card(4'd6);
    tick();
    new_Game = 1'b1;
    tick();
    new_Game = 1'b0;
    checks++;
    if (card_req !== 1'b0 || totalValueSlave5 !== 5'd0 || totalValueMaster5 !== 5'd0 ||
        result2 !== 2'b00) begin
      errors++;
      $display("FAIL restart_clear actual=%b/%0d/%0d/%b required=0/0/0/00",
               card_req, totalValueSlave5, totalValueMaster5, result2);
    end
    tick();
    checks++;
    if (card_req !== 1'b1) begin
      errors++;
      $display("FAIL restart_req_rise actual=%b required=1", card_req);
    end
    give_card(4'd7);
    checks++;
    if (cardReadySlave !== 1'b1 || totalValueSlave5 !== 5'd7 || totalValueMaster5 !== 5'd0 ||
        bcdResults16 !== 16'h0300) begin
      errors++;
      $display("FAIL restart_deal actual=%b/%0d/%0d/%h required=1/7/0/0300",
               cardReadySlave, totalValueSlave5, totalValueMaster5, bcdResults16);
    end
  endtask

  initial begin
    reset = 1'b1;
    new_Game = 1'b0;
    slave_hit = 1'b0;
    slave_stand = 1'b0;
    card_valid = 1'b0;
    cardValue4 = 4'd0;
    test_reset();
    test_basic_round();
    test_slave_bust();
    test_max_cards();
    test_hit_stand_and_stray();
    test_tie_and_master_bust();
    test_bcd_wrap();
    test_restart_mid_deal();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/deal_scheduler.md
Name: deal_scheduler

Overview:
- Sequences one blackjack round between the slave hand (player) and the master hand (dealer).
- Both hands share the single card source, the LFSR-based card generator. The block issues card requests and routes each returned card to the correct hand.
- Decides each hand's turn end, scores the round, and keeps BCD win counters for the score display.

Parameters:
- DEALER_STAND, 17: master draws while its total is below this value.
- BUST_LIMIT, 21: a total greater than this is a bust.
- MAX_CARDS, 5: slave turn ends automatically when the slave holds this many cards.

Ports:
- clock  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- new_Game  in  1  start a new round; level sampled each cycle.
- slave_hit  in  1  player requests a card; single-cycle pulse.
- slave_stand  in  1  player ends turn; single-cycle pulse.
- card_valid  in  1  card generator presents a card this cycle.
- cardValue4  in  4  card rank from the generator.
- card_req  out  1  request for the next card from the generator.
- cardReadySlave  out  1  one-cycle pulse: a card was added to the slave hand.
- cardReadyMaster  out  1  one-cycle pulse: a card was added to the master hand.
- totalValueSlave5  out  5  slave hand total.
- totalValueMaster5  out  5  master hand total.
- finishSlave  out  1  slave turn is over; held until the next round.
- finishMaster  out  1  master turn is over; held until the next round.
- result2  out  2  round outcome: 00 none, 01 slave win, 10 master win, 11 tie.
- bcdResults16  out  16  [15:8] master wins, [7:0] slave wins; each field is two BCD digits.

Behaviour:
- Reset: all outputs 0, state IDLE, card counts 0.
- States: IDLE, DEAL_S1, DEAL_M1, DEAL_S2, DEAL_M2, SLAVE_TURN, SLAVE_DRAW, MASTER_TURN, MASTER_DRAW, SCORE, DONE.
- Card handshake:
  - card_req is driven high while the state is DEAL_x, SLAVE_DRAW or MASTER_DRAW and no card has yet been accepted in that state.
  - A card is accepted on the cycle card_req and card_valid are both high. It is added to the target hand's total and count, and that hand's cardReady pulse is asserted the following cycle.
  - card_valid while card_req is low is ignored.
  - There is no timeout; the block waits indefinitely for a card.
- Card value: cardValue4 1..10 adds its value; 0 and 11..15 add 10.
- Totals saturate at 31.
- new_Game sampled high in any state, including mid-handshake:
  - Totals, counts, finish flags and result2 clear.
  - card_req drops for one cycle.
  - Next state is DEAL_S1; card_req rises at the second cycle after the sample.
  - bcdResults16 is not cleared.
- Deal order: DEAL_S1 → DEAL_M1 → DEAL_S2 → DEAL_M2 → SLAVE_TURN, one accepted card per state.
- SLAVE_TURN:
  - slave_stand → finishSlave=1, go to MASTER_TURN.
  - slave_hit → SLAVE_DRAW; after the card is accepted, return to SLAVE_TURN.
  - slave_hit and slave_stand in the same cycle: stand wins.
  - slave_hit while in SLAVE_DRAW is ignored.
  - The turn also ends (finishSlave=1) when the slave total exceeds BUST_LIMIT, or when the slave count equals MAX_CARDS and the slave has not busted. Both checks are made the cycle after the card is accepted.
- MASTER_TURN:
  - If the slave busted: finishMaster=1 immediately, no card request, go to SCORE.
  - Else if master total < DEALER_STAND: go to MASTER_DRAW, then back to MASTER_TURN.
  - Else: finishMaster=1, go to SCORE.
  - Slave inputs are ignored outside SLAVE_TURN.
- SCORE (one cycle), outcome decided in this priority order:
  1. slave bust → master win;
  2. master bust → slave win;
  3. higher total wins;
  4. equal totals → tie (11).
  - The winner's BCD counter increments; a tie increments neither.
  - Each counter wraps 99 → 00; the digits 9 → 0 carry into the tens digit.
  - Then go to DONE, holding result2 and the totals until new_Game.
- IDLE and DONE: card_req is 0.

Test Plan:
- Reset mid-DEAL_M1 with card_req high → all outputs 0 on the same cycle, state IDLE, bcdResults16=0x0000.
- new_Game pulse, then cards 10,7,5,9; slave_stand; card 3 →
  - totals slave 15, master 16 after dealing;
  - master draws once, reaching 19;
  - result2=10, bcdResults16=0x0100.
- Deal 10,2,6,3; slave_hit with card 12 → slave total 26 (bust), finishSlave=1, finishMaster=1 with no further card_req, result2=10.
- Deal 2,10,3,10 (master 20); slave hits with 2, 4, 5 → count reaches MAX_CARDS at total 16, finishSlave=1 with no stand; result2=10.
- slave_hit and slave_stand in the same cycle → no card_req, finishSlave=1. Separately, card_valid with card_req low → totals unchanged.
- Preload slave wins to 99; play a slave-win round (deal 10,10,10,7, slave_stand; master total 17 stands) → bcdResults16[7:0]=0x00, [15:8] unchanged.
- new_Game asserted while waiting in DEAL_S2 → card_req low for one cycle, totals 0, deal restarts at DEAL_S1, counters unchanged.
